ram_wr_seq: RTL
===============

// Module: ram_wr_seq
// PURPOSE
//   Parametrised write-side sequencer for the dual-port RAM test harness.
//   On a start pulse it sweeps port A over DEPTH addresses, writing one of four
//   selectable data patterns, and raises rd_flag once the read side may begin.
//   Supports single-pass or continuous (wrapping) operation with a graceful stop.
//   Sits between the top-level test controller and RAM port A.
// PARAMETERS
//   ADDR_W    6    RAM address width
//   DATA_W    8    RAM data width
//   DEPTH     64   words per pass, 2 <= DEPTH <= 2**ADDR_W
//   RD_START  32   words written before rd_flag asserts, 1 <= RD_START <= DEPTH
// PORTS
//   clk          in   1        clock
//   rst_n        in   1        asynchronous reset, active-low
//   start        in   1        begin a run; honoured only in IDLE
//   stop         in   1        end run at the end of the current pass
//   continuous   in   1        1: wrap and repeat passes; 0: single pass
//   mode         in   2        pattern select, latched on start
//   seed         in   DATA_W   pattern seed, latched on start
//   ram_wr_en    out  1        port A enable
//   ram_wr_we    out  1        port A write enable, always equal to ram_wr_en
//   ram_wr_addr  out  ADDR_W   port A address
//   ram_wr_data  out  DATA_W   port A write data
//   rd_flag      out  1        sticky: read side may start
//   busy         out  1        high while in WRITE
//   done         out  1        one-cycle pulse at end of run
//   pass_cnt     out  16       completed passes in the current run
// BEHAVIOUR
//   Reset: all outputs 0, FSM in IDLE, latched mode and seed 0. Async assert, sync release.
//   FSM states:
//     IDLE -> WRITE   on start=1
//     WRITE -> WRITE  each cycle, addr+1
//     WRITE at addr DEPTH-1:
//       if continuous=1 and no stop pending: addr -> 0, stay in WRITE
//       otherwise: go to DONE
//     DONE -> IDLE    after exactly 1 cycle
//   Latency: start sampled at edge k -> from edge k+1, ram_wr_en=1 and addr=0.
//     All outputs are registered.
//   WRITE: ram_wr_en=1 on every cycle, with no gaps between words or at wrap.
//   IDLE/DONE: ram_wr_en=0 and ram_wr_addr=0.
//   stop: a 1 sampled in any WRITE cycle sets stop_pend.
//     The current pass always completes through DEPTH-1.
//     stop_pend is cleared on entering IDLE.
//   done: 1 only in the DONE cycle. busy: 1 only in WRITE.
//   pass_cnt:
//     cleared when a new start is accepted
//     +1 on each write to DEPTH-1, including the final pass
//     saturates at 16'hFFFF
//   rd_flag:
//     cleared when a new start is accepted
//     set the cycle after the write to addr RD_START-1; held until the next start
//     also held through DONE and IDLE
//   Data patterns (A = addr zero-extended or truncated to DATA_W; mod 2**DATA_W):
//     mode 0: A
//     mode 1: ~A
//     mode 2: seed + A
//     mode 3: A[0] ? ~seed : seed   (checkerboard)
//   ram_wr_data is aligned with the ram_wr_addr of the same cycle.
//   mode and seed are latched on an accepted start; changes mid-run are ignored.
//   start while busy or in DONE: ignored, no side effects.
//   start and stop both 1 in IDLE: start accepted; stop is ignored because
//     stop_pend is only set in WRITE.
//   continuous changed mid-run: sampled only at addr DEPTH-1.
//   rst_n low mid-run: immediate return to reset values; a new start is
//     required after release.
// TESTING
//   1. Defaults, mode=0, continuous=0, start pulse:
//      64 consecutive writes, addr 0..63, data = addr;
//      rd_flag rises the cycle after addr 31; done pulses once; pass_cnt = 1.
//   2. mode=2, seed=8'hF0:
//      addr 15 -> data 8'hFF; addr 16 -> data 8'h00 (wrap);
//      mode=3, seed=8'hA5: data alternates A5/5A.
//   3. continuous=1, stop pulsed at addr 10 of pass 3:
//      writes continue to 63 with no gap at the 63->0 wrap;
//      done follows; pass_cnt = 3.
//   4. start pulsed during WRITE and during DONE:
//      no restart, and addr/pass_cnt are undisturbed.
//   5. rst_n dropped at addr 40:
//      all outputs 0 asynchronously; after release, IDLE with ram_wr_en=0
//      until the next start.
//   6. DEPTH=16, RD_START=16, ADDR_W=5, DATA_W=4:
//      rd_flag rises after addr 15; mode 0 data = addr[3:0].

Source files
------------

// File: rtl/ram_wr_seq_if.sv
// RAM port A bus driven by the write sequencer.
//   ram_wr_en    port A enable
//   ram_wr_we    port A write enable (mirrors ram_wr_en)
//   ram_wr_addr  port A address, ADDR_W bits
//   ram_wr_data  port A write data, DATA_W bits
// master: the sequencer side (drives everything); slave: the RAM side.
interface ram_wr_seq_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              ram_wr_en;
  logic              ram_wr_we;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;

  modport master (
    output ram_wr_en,
    output ram_wr_we,
    output ram_wr_addr,
    output ram_wr_data
  );

  modport slave (
    input ram_wr_en,
    input ram_wr_we,
    input ram_wr_addr,
    input ram_wr_data
  );
endinterface

// File: rtl/ram_wr_seq.sv
// Write-side sequencer for the dual-port RAM test harness.
// A start pulse in IDLE launches a sweep of port A over DEPTH addresses.
// Each word carries one of four data patterns. rd_flag is raised once
// RD_START words have been written. The sweep runs once, or wraps
// continuously until a stop request, which lets the current pass finish.
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset (released synchronously)
//   start        begin a run (honoured only in IDLE)
//   stop         end the run at the end of the current pass
//   continuous   1: wrap and repeat passes, 0: single pass
//   mode, seed   pattern select / seed, latched on an accepted start
//   ram          port A bus (ram_wr_seq_if.master)
//   rd_flag      sticky "read side may start"
//   busy         high while writing
//   done         one-cycle pulse at the end of a run
//   pass_cnt     completed passes in the current run (saturating)
module ram_wr_seq #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int RD_START = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  ram_wr_seq_if.master      ram,
  output logic              rd_flag,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] RD_ADDR   = ADDR_W'(RD_START - 1);

  state_t            state;
  logic [1:0]        rst_q;
  logic              rst_sync_n;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic              stop_pend;
  logic              stop_now;

  // Reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_sync_n = rst_q[1];

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] av;
    av = DATA_W'(a);
    case (m)
      2'd0:    pattern = av;
      2'd1:    pattern = ~av;
      2'd2:    pattern = s + av;
      default: pattern = a[0] ? ~s : s;
    endcase
  endfunction

  // A stop arriving in the final cycle of a pass still ends the run there.
  assign stop_now = stop_pend | stop;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= S_IDLE;
      en        <= 1'b0;
      addr      <= '0;
      data      <= '0;
      mode_q    <= '0;
      seed_q    <= '0;
      stop_pend <= 1'b0;
      rd_flag   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WRITE;
            en        <= 1'b1;
            busy      <= 1'b1;
            addr      <= '0;
            // Inputs used directly: the latched copies are not valid yet.
            data      <= pattern(mode, seed, '0);
            mode_q    <= mode;
            seed_q    <= seed;
            stop_pend <= 1'b0;
            rd_flag   <= 1'b0;
            pass_cnt  <= '0;
          end
        end

        S_WRITE: begin
          if (stop) stop_pend <= 1'b1;
          if (addr == RD_ADDR) rd_flag <= 1'b1;
          if (addr == LAST_ADDR) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 16'd1;
            if (continuous && !stop_now) begin
              addr <= '0;
              data <= pattern(mode_q, seed_q, '0);
            end else begin
              state <= S_DONE;
              en    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              addr  <= '0;
              data  <= '0;
            end
          end else begin
            addr <= addr + ADDR_W'(1);
            data <= pattern(mode_q, seed_q, addr + ADDR_W'(1));
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          stop_pend <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          en    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          addr  <= '0;
          data  <= '0;
        end
      endcase
    end
  end

  assign ram.ram_wr_en   = en;
  assign ram.ram_wr_we   = en;
  assign ram.ram_wr_addr = addr;
  assign ram.ram_wr_data = data;

endmodule
